// File: rtl/tile_line_fetcher_pkg.sv
// Shared geometry, FSM encodings and helpers for the tile scanline fetcher.
// The row-base helper is hard-wired for H_TILES = 80.
package tile_line_fetcher_pkg;

  localparam int TILE_W      = 8;
  localparam int H_TILES     = 80;
  localparam int V_TILES     = 60;
  localparam int ACTIVE_W    = 640;
  localparam int NT_AW       = 13;
  localparam int TILE_RD_LAT = 1;
  localparam int LINE_PX     = H_TILES * TILE_W;
  localparam int FRAME_PX    = V_TILES * TILE_W;
  // The last address issued takes name RAM + tile RAM + output register to retire.
  localparam int DRAIN_CYC   = TILE_RD_LAT + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // (y >> 3) * 80 as (r << 6) + (r << 4), so no multiplier is inferred.
  function automatic logic [NT_AW-1:0] row_base_of(input logic [8:0] y);
    logic [NT_AW-1:0] r;
    r = NT_AW'(y[8:3]);
    return (r << 6) + (r << 4);
  endfunction

endpackage

// File: rtl/tile_line_fetcher_addr_gen.sv
// Name-table address generator: latches the scrolled row on line start, then walks
// the horizontal position one pixel per step with wrap at the end of the map row.
module tile_line_fetcher_addr_gen
  import tile_line_fetcher_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [8:0]       line_y,
  input  logic [9:0]       scroll_x,
  input  logic [8:0]       scroll_y,
  output logic [NT_AW-1:0] nt_addr,
  output logic [2:0]       fx,
  output logic [2:0]       fine_y
);

  logic [9:0]       x_q, x_d;
  logic [NT_AW-1:0] row_base_q, row_base_d;
  logic [2:0]       fine_y_q, fine_y_d;
  logic [NT_AW-1:0] nt_addr_q, nt_addr_d;
  logic [2:0]       fx_q, fx_d;

  logic [9:0]       y_sum;
  logic [8:0]       y_eff;
  logic [9:0]       x0;
  logic [9:0]       x_cur;
  logic [NT_AW-1:0] rb_cur;

  always_comb begin
    y_sum = {1'b0, line_y} + {1'b0, scroll_y};
    y_eff = (y_sum >= 10'(FRAME_PX)) ? 9'(y_sum - 10'(FRAME_PX)) : y_sum[8:0];
    x0    = (scroll_x >= 10'(LINE_PX)) ? scroll_x - 10'(LINE_PX) : scroll_x;

    // On load the first address is built straight from the fresh scroll values.
    x_cur  = load ? x0 : x_q;
    rb_cur = load ? row_base_of(y_eff) : row_base_q;

    x_d        = x_q;
    row_base_d = row_base_q;
    fine_y_d   = fine_y_q;
    nt_addr_d  = nt_addr_q;
    fx_d       = fx_q;

    if (load) begin
      row_base_d = rb_cur;
      fine_y_d   = y_eff[2:0];
    end
    if (load || step) begin
      nt_addr_d = rb_cur + NT_AW'(x_cur[9:3]);
      fx_d      = x_cur[2:0];
      x_d       = (x_cur == 10'(LINE_PX - 1)) ? 10'd0 : x_cur + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      row_base_q <= '0;
      fine_y_q   <= '0;
      nt_addr_q  <= '0;
      fx_q       <= '0;
    end else begin
      x_q        <= x_d;
      row_base_q <= row_base_d;
      fine_y_q   <= fine_y_d;
      nt_addr_q  <= nt_addr_d;
      fx_q       <= fx_d;
    end
  end

  assign nt_addr = nt_addr_q;
  assign fx      = fx_q;
  assign fine_y  = fine_y_q;

endmodule

// File: rtl/tile_line_fetcher.sv
// Scanline sequencer: name-table walk, tile RAM addressing and a 4-cycle pixel
// pipeline (address, name, tile pixel, output register) with abort/restart.
module tile_line_fetcher
  import tile_line_fetcher_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             line_start,
  input  logic [8:0]       line_y,
  input  logic [9:0]       scroll_x,
  input  logic [8:0]       scroll_y,
  output logic [NT_AW-1:0] nt_addr,
  input  logic [7:0]       nt_data,
  output logic [7:0]       tile_name,
  output logic [2:0]       tile_row,
  output logic [2:0]       tile_column,
  input  logic [1:0]       tile_px,
  output logic [1:0]       px_out,
  output logic             px_valid,
  output logic             busy
);

  fetch_state_e state_q, state_d;
  logic [9:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         vld_p0_q, vld_p0_d;
  logic         vld_p1_q, vld_p1_d;
  logic         vld_p2_q, vld_p2_d;
  logic [2:0]   tile_row_q, tile_row_d;
  logic [2:0]   tile_column_q, tile_column_d;
  logic [7:0]   name_hold_q, name_hold_d;
  logic [1:0]   px_out_q, px_out_d;
  logic         px_valid_q, px_valid_d;

  logic         step;
  logic [2:0]   fx;
  logic [2:0]   fine_y;

  assign step = (state_q == ST_RUN) && (cnt_q != 10'(ACTIVE_W - 1));

  tile_line_fetcher_addr_gen u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (line_start),
    .step     (step),
    .line_y   (line_y),
    .scroll_x (scroll_x),
    .scroll_y (scroll_y),
    .nt_addr  (nt_addr),
    .fx       (fx),
    .fine_y   (fine_y)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tile_row_d    = tile_row_q;
    tile_column_d = tile_column_q;
    name_hold_d   = name_hold_q;
    px_out_d      = px_out_q;

    case (state_q)
      ST_RUN: begin
        if (cnt_q == 10'(ACTIVE_W - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 10'(DRAIN_CYC - 1)) state_d = ST_IDLE;
        else                              cnt_d   = cnt_q + 10'd1;
      end
      default: ;
    endcase
    if (line_start) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end
    busy_d = (state_d != ST_IDLE);

    // S0 -> S1: address out, name RAM reading; column/row ride alongside.
    vld_p0_d = (state_d == ST_RUN);
    if (vld_p0_q) begin
      tile_row_d    = fine_y;
      tile_column_d = fx;
    end
    // S1 -> S2: name forwarded to the tile RAM, kept for the idle hold value.
    vld_p1_d = vld_p0_q & ~line_start;
    if (vld_p1_q) name_hold_d = nt_data;
    // S2 -> S3: tile RAM pixel captured into the output register.
    vld_p2_d   = vld_p1_q & ~line_start;
    px_valid_d = vld_p2_q & ~line_start;
    if (vld_p2_q) px_out_d = tile_px;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      vld_p0_q      <= 1'b0;
      vld_p1_q      <= 1'b0;
      vld_p2_q      <= 1'b0;
      tile_row_q    <= '0;
      tile_column_q <= '0;
      name_hold_q   <= '0;
      px_out_q      <= '0;
      px_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      vld_p0_q      <= vld_p0_d;
      vld_p1_q      <= vld_p1_d;
      vld_p2_q      <= vld_p2_d;
      tile_row_q    <= tile_row_d;
      tile_column_q <= tile_column_d;
      name_hold_q   <= name_hold_d;
      px_out_q      <= px_out_d;
      px_valid_q    <= px_valid_d;
    end
  end

  // The name RAM output is only meaningful while a name is in S1.
  assign tile_name   = vld_p1_q ? nt_data : name_hold_q;
  assign tile_row    = tile_row_q;
  assign tile_column = tile_column_q;
  assign px_out      = px_out_q;
  assign px_valid    = px_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tile_line_fetcher.sv
// Scoreboard bench for tile_line_fetcher with behavioural name-table and tile RAMs.
module tb_tile_line_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [8:0]  line_y;
  logic [9:0]  scroll_x;
  logic [8:0]  scroll_y;
  logic [12:0] nt_addr;
  logic [7:0]  nt_data = '0;
  logic [7:0]  tile_name;
  logic [2:0]  tile_row;
  logic [2:0]  tile_column;
  logic [1:0]  tile_px = '0;
  logic [1:0]  px_out;
  logic        px_valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int cyc      = 0;
  logic [1:0] sb[$];
  logic [1:0] mon_exp;

  always #5 clk = ~clk;

  tile_line_fetcher dut (
    .clk         (clk),
    .reset       (reset),
    .line_start  (line_start),
    .line_y      (line_y),
    .scroll_x    (scroll_x),
    .scroll_y    (scroll_y),
    .nt_addr     (nt_addr),
    .nt_data     (nt_data),
    .tile_name   (tile_name),
    .tile_row    (tile_row),
    .tile_column (tile_column),
    .tile_px     (tile_px),
    .px_out      (px_out),
    .px_valid    (px_valid),
    .busy        (busy)
  );

  // RAM models: one cycle read latency each.
  always @(posedge clk) begin
    nt_data <= nt_addr[7:0];
    tile_px <= tile_column[1:0] ^ tile_name[1:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (px_valid === 1'b1) begin
      n_valid++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL px_unexpected: got px_out %0d, expected no pixel (t=%0t)", px_out, $time);
      end else begin
        mon_exp = sb.pop_front();
        check("px_out", 32'(px_out), 32'(mon_exp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_line(input int ly, input int sx, input int sy);
    int y, x0, x, addr;
    y  = ly + sy;
    if (y >= 480) y = y - 480;
    x0 = (sx >= 640) ? sx - 640 : sx;
    for (int k = 0; k < 640; k++) begin
      x    = (x0 + k) % 640;
      addr = (y / 8) * 80 + x / 8;
      sb.push_back(2'(((x % 8) & 3) ^ (addr & 3)));
    end
  endtask

  // Drives line_start during the current cycle; returns inside cycle T+1 (cyc = 1).
  task automatic start_line(input int ly, input int sx, input int sy, input bit restart);
    if (!restart) check("sb_drained", 32'(sb.size()), 32'd0);
    line_y     = 9'(ly);
    scroll_x   = 10'(sx);
    scroll_y   = 9'(sy);
    line_start = 1'b1;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    line_y     = 9'd123;
    scroll_x   = 10'd77;
    scroll_y   = 9'd33;
    if (restart) sb.delete();
    push_line(ly, sx, sy);
    cyc = 1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(n >= 1000), 32'd0);
    repeat (2) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_px_out"},      32'(px_out),      32'd0);
    check({tag, "_px_valid"},    32'(px_valid),    32'd0);
    check({tag, "_nt_addr"},     32'(nt_addr),     32'd0);
    check({tag, "_tile_name"},   32'(tile_name),   32'd0);
    check({tag, "_tile_row"},    32'(tile_row),    32'd0);
    check({tag, "_tile_column"}, 32'(tile_column), 32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int vld_seen;
    reset = 1'b1; line_start = 1'b0;
    line_y = '0; scroll_x = '0; scroll_y = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_all_zero("reset");

    // Plain line, no scroll.
    start_line(0, 0, 0, 1'b0);
    while (cyc <= 645) begin
      if (cyc <= 8)   check("l0_nt_addr_tile0", 32'(nt_addr), 32'd0);
      if (cyc == 9)   check("l0_nt_addr_tile1", 32'(nt_addr), 32'd1);
      if (cyc == 1)   check("l0_busy_T1", 32'(busy), 32'd1);
      if (cyc == 3)   check("l0_valid_T3", 32'(px_valid), 32'd0);
      if (cyc == 4)   check("l0_valid_T4", 32'(px_valid), 32'd1);
      if (cyc == 643) check("l0_valid_T643", 32'(px_valid), 32'd1);
      if (cyc == 643) check("l0_busy_T643", 32'(busy), 32'd1);
      if (cyc == 644) check("l0_valid_T644", 32'(px_valid), 32'd0);
      if (cyc == 644) check("l0_busy_T644", 32'(busy), 32'd0);
      step();
    end
    wait_idle();

    // Fine horizontal scroll.
    start_line(0, 5, 0, 1'b0);
    while (cyc <= 6) begin
      if (cyc <= 3) check("sx5_nt_addr_first", 32'(nt_addr), 32'd0);
      if (cyc == 4) check("sx5_nt_addr_next", 32'(nt_addr), 32'd1);
      if (cyc == 2) check("sx5_tile_column", 32'(tile_column), 32'd5);
      step();
    end
    wait_idle();

    // Horizontal wrap at the right edge of the map.
    start_line(8, 636, 0, 1'b0);
    while (cyc <= 7) begin
      if (cyc <= 4) check("hwrap_nt_addr_159", 32'(nt_addr), 32'd159);
      if (cyc == 5) check("hwrap_nt_addr_80", 32'(nt_addr), 32'd80);
      if (cyc >= 2 && cyc <= 5) check("hwrap_tile_column", 32'(tile_column), 32'(cyc + 2));
      if (cyc == 6) check("hwrap_tile_column_wrap", 32'(tile_column), 32'd0);
      step();
    end
    wait_idle();

    // Vertical wrap: 470 + 20 - 480 = 10.
    start_line(470, 0, 20, 1'b0);
    while (cyc <= 641) begin
      if (cyc == 1) check("vwrap_nt_addr", 32'(nt_addr), 32'd80);
      if (cyc == 2 || cyc == 300 || cyc == 641) check("vwrap_tile_row", 32'(tile_row), 32'd2);
      step();
    end
    wait_idle();

    // Restart after 100 pixels.
    n_valid = 0;
    start_line(0, 0, 0, 1'b0);
    repeat (102) step();
    start_line(1, 0, 0, 1'b1);
    while (cyc <= 4) begin
      if (cyc <= 3) check("restart_gap_valid", 32'(px_valid), 32'd0);
      if (cyc == 4) check("restart_resume_valid", 32'(px_valid), 32'd1);
      if (cyc == 2) check("restart_tile_row", 32'(tile_row), 32'd1);
      step();
    end
    wait_idle();
    check("restart_valid_count", 32'(n_valid), 32'd740);

    // Reset in the middle of a line, at pixel 50.
    start_line(16, 0, 0, 1'b0);
    repeat (53) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    check_all_zero("midreset");
    vld_seen = 0;
    repeat (20) begin
      step();
      if (px_valid !== 1'b0 || busy !== 1'b0) vld_seen++;
    end
    check("midreset_quiet", 32'(vld_seen), 32'd0);

    // line_start coincident with reset must not start a line.
    reset = 1'b1; line_start = 1'b1;
    step();
    reset = 1'b0; line_start = 1'b0;
    vld_seen = 0;
    repeat (10) begin
      if (px_valid !== 1'b0 || busy !== 1'b0) vld_seen++;
      step();
    end
    check("reset_wins_quiet", 32'(vld_seen), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
